// File: rtl/mc_pkg.sv
// Shared constants and types for the multi-cycle MIPS-subset main control FSM.
package mc_pkg;

    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_EXEC_R = 4'd2;
    localparam logic [3:0] ST_EXEC_I = 4'd3;
    localparam logic [3:0] ST_ADDR   = 4'd4;
    localparam logic [3:0] ST_MEM_RD = 4'd5;
    localparam logic [3:0] ST_MEM_WR = 4'd6;
    localparam logic [3:0] ST_WB_ALU = 4'd7;
    localparam logic [3:0] ST_WB_MEM = 4'd8;
    localparam logic [3:0] ST_BRANCH = 4'd9;
    localparam logic [3:0] ST_JUMP   = 4'd10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic [1:0] pcsrc;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       alusrc;
        logic [1:0] aluop;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       retire;
    } ctrl_t;

    // States that wait on the memory handshake and run the timeout counter.
    function automatic logic is_mem_state(input logic [3:0] s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_outdec.sv
// Combinational decode of registered state (plus mem_ready/zero qualifiers) into
// datapath selects and strobes.
module mc_outdec
    import mc_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] op_q,
    input  logic       mem_ready,
    input  logic       zero,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.memread = 1'b1;
                ctrl.aluop   = ALU_ADD;
                if (mem_ready) begin
                    ctrl.irwrite = 1'b1;
                    ctrl.pcwrite = 1'b1;
                    ctrl.pcsrc   = PC_SEQ;
                end
            end
            ST_EXEC_R: begin
                ctrl.alusrc = 1'b0;
                ctrl.aluop  = ALU_FUNCT;
            end
            ST_EXEC_I, ST_ADDR: begin
                ctrl.alusrc = 1'b1;
                ctrl.aluop  = ALU_ADD;
            end
            ST_MEM_RD: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.memwrite = 1'b1;
                ctrl.iord     = 1'b1;
                ctrl.retire   = mem_ready;
            end
            ST_WB_ALU: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = (op_q == OP_RTYPE);
                ctrl.retire   = 1'b1;
            end
            ST_WB_MEM: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.retire   = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.aluop   = ALU_SUB;
                ctrl.pcsrc   = PC_BRANCH;
                ctrl.pcwrite = zero;
                ctrl.retire  = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pcwrite = 1'b1;
                ctrl.pcsrc   = PC_JUMP;
                ctrl.retire  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle main control FSM: state register, latched opcode and memory wait
// timeout; output decode lives in mc_outdec.
module mc_control
    import mc_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic [1:0] pcsrc,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       alusrc,
    output logic [1:0] aluop,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       retire,
    output logic       illegal,
    output logic       memerr,
    output logic [3:0] state
);

    localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

    logic [3:0] state_q, state_d;
    logic [5:0] op_q;
    logic [7:0] wait_q, wait_d;
    logic       abort;
    logic       illegal_c;
    ctrl_t      ctrl;

    // mem_ready on the limit cycle takes priority over the abort.
    assign abort = is_mem_state(state_q) && !mem_ready && (wait_q == LIMIT_M1);

    always_comb begin
        state_d   = state_q;
        illegal_c = 1'b0;
        case (state_q)
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = ST_EXEC_R;
                    OP_ADDI:      state_d = ST_EXEC_I;
                    OP_LW, OP_SW: state_d = ST_ADDR;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    default: begin
                        state_d   = ST_FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            ST_EXEC_R, ST_EXEC_I: state_d = ST_WB_ALU;
            ST_ADDR:   state_d = (op_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
                if (mem_ready)  state_d = ST_WB_MEM;
                else if (abort) state_d = ST_FETCH;
            end
            ST_MEM_WR: if (mem_ready || abort) state_d = ST_FETCH;
            default:   state_d = ST_FETCH;
        endcase
    end

    // Counter restarts on every state entry, including an abort back into FETCH.
    always_comb begin
        wait_d = wait_q;
        if ((state_d != state_q) || abort) begin
            wait_d = '0;
        end else if (is_mem_state(state_q) && !mem_ready) begin
            wait_d = wait_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            op_q    <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == ST_DECODE) op_q <= opcode;
        end
    end

    mc_outdec u_outdec (
        .state     (state_q),
        .op_q      (op_q),
        .mem_ready (mem_ready),
        .zero      (zero),
        .ctrl      (ctrl)
    );

    assign pcwrite  = ctrl.pcwrite  & ~rst;
    assign pcsrc    = rst ? 2'b00 : ctrl.pcsrc;
    assign iord     = ctrl.iord     & ~rst;
    assign memread  = ctrl.memread  & ~rst;
    assign memwrite = ctrl.memwrite & ~rst;
    assign irwrite  = ctrl.irwrite  & ~rst;
    assign alusrc   = ctrl.alusrc   & ~rst;
    assign aluop    = rst ? 2'b00 : ctrl.aluop;
    assign regwrite = ctrl.regwrite & ~rst;
    assign regdst   = ctrl.regdst   & ~rst;
    assign memtoreg = ctrl.memtoreg & ~rst;
    assign retire   = ctrl.retire   & ~rst;
    assign illegal  = illegal_c     & ~rst;
    assign memerr   = abort         & ~rst;
    assign state    = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: an instruction-level model expands each instruction
// into expected per-cycle outputs, checked every cycle, plus literal latency/count checks.
module tb_mc_control;

    localparam int LIMIT = 4;
    localparam logic [5:0] JUNK = 6'h3F;

    typedef struct packed {
        logic [3:0] st;
        logic       pcwrite;
        logic [1:0] pcsrc;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       alusrc;
        logic [1:0] aluop;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       retire;
        logic       illegal;
        logic       memerr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pcwrite, iord, memread, memwrite, irwrite, alusrc;
    logic       regwrite, regdst, memtoreg, retire, illegal, memerr;
    logic [1:0] pcsrc, aluop;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0, retire_cnt = 0, memerr_cnt = 0, illegal_cnt = 0;
    int regwrite_cnt = 0, memwrite_cnt = 0, mrd_cnt = 0, brpc_cnt = 0;
    exp_t exp_q[$];

    mc_control #(.WAIT_LIMIT(LIMIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pcwrite   (pcwrite),
        .pcsrc     (pcsrc),
        .iord      (iord),
        .memread   (memread),
        .memwrite  (memwrite),
        .irwrite   (irwrite),
        .alusrc    (alusrc),
        .aluop     (aluop),
        .regwrite  (regwrite),
        .regdst    (regdst),
        .memtoreg  (memtoreg),
        .retire    (retire),
        .illegal   (illegal),
        .memerr    (memerr),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Single compare process: every cycle that has an expectation is checked.
    always @(negedge clk) begin
        exp_t e, act;
        act = {state, pcwrite, pcsrc, iord, memread, memwrite, irwrite, alusrc, aluop,
               regwrite, regdst, memtoreg, retire, illegal, memerr};
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            cyc_cnt++;
            if (act !== e) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t actual=%b required=%b", $time, act, e);
            end
        end
        if (retire === 1'b1) retire_cnt++;
        if (memerr === 1'b1) memerr_cnt++;
        if (illegal === 1'b1) illegal_cnt++;
        if (regwrite === 1'b1) regwrite_cnt++;
        if (memwrite === 1'b1) memwrite_cnt++;
        if (state == 4'd5 && memread === 1'b1) mrd_cnt++;
        if (state == 4'd9 && pcwrite === 1'b1) brpc_cnt++;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic exp_t blank(input int st);
        exp_t e;
        e = '0;
        e.st = st[3:0];
        return e;
    endfunction

    task automatic cyc(input logic [5:0] opc, input logic mr, input logic z, input exp_t e);
        opcode    = opc;
        mem_ready = mr;
        zero      = z;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // One memory-handshake state: stall for wt cycles, abort at the LIMIT-th stalled cycle.
    task automatic mem_phase(input int st, input int wt, output bit ok);
        exp_t e;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            e = blank(st);
            if (st == 0) e.memread = 1'b1;
            else if (st == 5) begin e.memread = 1'b1; e.iord = 1'b1; end
            else begin e.memwrite = 1'b1; e.iord = 1'b1; end
            if (k >= wt) begin
                if (st == 0) begin e.irwrite = 1'b1; e.pcwrite = 1'b1; end
                if (st == 6) e.retire = 1'b1;
                cyc(JUNK, 1'b1, 1'b1, e);
                ok = 1'b1;
                return;
            end
            if (k == LIMIT - 1) begin
                e.memerr = 1'b1;
                cyc(JUNK, 1'b0, 1'b1, e);
                return;
            end
            cyc(JUNK, 1'b0, 1'b1, e);
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input int fwait, input int mwait,
                             input logic z);
        exp_t e;
        bit   ok;
        mem_phase(0, fwait, ok);
        if (!ok) return;
        e = blank(1);
        if (!(op inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02})) begin
            e.illegal = 1'b1;
            cyc(op, 1'b0, 1'b1, e);
            return;
        end
        cyc(op, 1'b0, 1'b1, e);
        case (op)
            6'h00, 6'h08: begin
                e = blank(op == 6'h00 ? 2 : 3);
                if (op == 6'h00) e.aluop = 2'b10;
                else e.alusrc = 1'b1;
                cyc(JUNK, 1'b1, 1'b1, e);
                e = blank(7);
                e.regwrite = 1'b1;
                e.regdst   = (op == 6'h00);
                e.retire   = 1'b1;
                cyc(JUNK, 1'b1, 1'b1, e);
            end
            6'h23, 6'h2B: begin
                e = blank(4);
                e.alusrc = 1'b1;
                cyc(JUNK, 1'b1, 1'b1, e);
                mem_phase(op == 6'h23 ? 5 : 6, mwait, ok);
                if (ok && op == 6'h23) begin
                    e = blank(8);
                    e.regwrite = 1'b1;
                    e.memtoreg = 1'b1;
                    e.retire   = 1'b1;
                    cyc(JUNK, 1'b0, 1'b1, e);
                end
            end
            6'h04: begin
                e = blank(9);
                e.aluop   = 2'b01;
                e.pcsrc   = 2'b01;
                e.pcwrite = z;
                e.retire  = 1'b1;
                cyc(JUNK, 1'b1, z, e);
            end
            default: begin
                e = blank(10);
                e.pcwrite = 1'b1;
                e.pcsrc   = 2'b10;
                e.retire  = 1'b1;
                cyc(JUNK, 1'b1, 1'b1, e);
            end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, r0, m0, i0, w0, d0, p0;
        exp_t e;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", int'(state), 0);
        chk("reset_outputs", int'({pcwrite, pcsrc, iord, memread, memwrite, irwrite, alusrc,
                                   aluop, regwrite, regdst, memtoreg, retire, illegal,
                                   memerr}), 0);
        rst = 1'b0;

        c0 = cyc_cnt; r0 = retire_cnt; w0 = regwrite_cnt;
        run_instr(6'h00, 0, 0, 1'b0);
        chk("lat_rtype", cyc_cnt - c0, 4);
        chk("retire_rtype", retire_cnt - r0, 1);
        chk("regwrite_rtype", regwrite_cnt - w0, 1);

        c0 = cyc_cnt;
        run_instr(6'h08, 2, 0, 1'b0);
        chk("lat_addi_fwait2", cyc_cnt - c0, 6);

        c0 = cyc_cnt; r0 = retire_cnt; d0 = mrd_cnt; m0 = memerr_cnt;
        run_instr(6'h23, 0, 3, 1'b0);
        chk("lat_lw_wait3", cyc_cnt - c0, 8);
        chk("memread_lw", mrd_cnt - d0, 4);
        chk("retire_lw", retire_cnt - r0, 1);
        chk("ready_beats_limit", memerr_cnt - m0, 0);

        c0 = cyc_cnt;
        run_instr(6'h2B, 0, 0, 1'b0);
        chk("lat_sw", cyc_cnt - c0, 4);

        c0 = cyc_cnt; r0 = retire_cnt; p0 = brpc_cnt;
        run_instr(6'h04, 0, 0, 1'b1);
        run_instr(6'h04, 0, 0, 1'b0);
        chk("lat_beq_x2", cyc_cnt - c0, 6);
        chk("retire_beq_x2", retire_cnt - r0, 2);
        chk("beq_taken_once", brpc_cnt - p0, 1);

        c0 = cyc_cnt;
        run_instr(6'h02, 0, 0, 1'b0);
        chk("lat_j", cyc_cnt - c0, 3);

        c0 = cyc_cnt; i0 = illegal_cnt; w0 = regwrite_cnt; d0 = memwrite_cnt; r0 = retire_cnt;
        run_instr(6'h3F, 0, 0, 1'b0);
        chk("lat_illegal", cyc_cnt - c0, 2);
        chk("illegal_pulse", illegal_cnt - i0, 1);
        chk("illegal_no_wr", (regwrite_cnt - w0) + (memwrite_cnt - d0) + (retire_cnt - r0), 0);

        c0 = cyc_cnt; m0 = memerr_cnt; d0 = memwrite_cnt; r0 = retire_cnt;
        run_instr(6'h2B, 0, 100, 1'b0);
        chk("lat_sw_timeout", cyc_cnt - c0, 7);
        chk("memwrite_timeout", memwrite_cnt - d0, 4);
        chk("memerr_sw", memerr_cnt - m0, 1);
        chk("retire_sw_timeout", retire_cnt - r0, 0);

        c0 = cyc_cnt; m0 = memerr_cnt;
        run_instr(6'h00, 100, 0, 1'b0);
        chk("lat_fetch_timeout", cyc_cnt - c0, 4);
        chk("memerr_fetch", memerr_cnt - m0, 1);

        c0 = cyc_cnt;
        run_instr(6'h08, 0, 0, 1'b0);
        chk("lat_after_abort", cyc_cnt - c0, 4);

        // Reset landing in the middle of EXEC_R.
        r0 = retire_cnt;
        e = blank(0); e.memread = 1'b1; e.irwrite = 1'b1; e.pcwrite = 1'b1;
        cyc(JUNK, 1'b1, 1'b1, e);
        cyc(6'h00, 1'b0, 1'b1, blank(1));
        e = blank(2); e.aluop = 2'b10;
        exp_q.push_back(e);
        opcode = JUNK;
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc(JUNK, 1'b1, 1'b1, blank(0));
        chk("rst_hold_state", int'(state), 0);
        cyc(JUNK, 1'b1, 1'b1, blank(0));
        rst = 1'b0;
        e = blank(0); e.memread = 1'b1;
        cyc(JUNK, 1'b0, 1'b1, e);
        chk("rst_no_retire", retire_cnt - r0, 0);
        run_instr(6'h02, 0, 0, 1'b0);
        chk("retire_after_rst", retire_cnt - r0, 1);

        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
